// File: rtl/fp_issue_queue.sv
// Issue queue between the core and an FP unit: a circular FIFO of instruction/rs1 pairs,
// with issue throttled by a count of ops sent to the FPU that have not yet produced a result.
module fp_issue_queue #(
  parameter int DEPTH        = 4,
  parameter int MAX_INFLIGHT = 4
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic                   flush_i,
  input  logic                   push_valid_i,
  output logic                   push_ready_o,
  input  logic [31:0]            instr_i,
  input  logic [31:0]            rs1_i,
  output logic                   pop_valid_o,
  input  logic                   pop_ready_i,
  output logic [31:0]            instr_o,
  output logic [31:0]            rs1_o,
  input  logic                   result_valid_i,
  input  logic                   result_ready_i,
  output logic [$clog2(DEPTH):0] count_o,
  output logic [3:0]             inflight_o,
  output logic                   busy_o,
  output logic                   err_o
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  typedef struct packed {
    logic [31:0] instr;
    logic [31:0] rs1;
  } entry_t;

  entry_t [DEPTH-1:0] mem_q, mem_d;
  logic [AW-1:0]      wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]      rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]      count_q, count_d;
  logic [3:0]         inflight_q, inflight_d;
  logic               err_q, err_d;

  logic push_hs, pop_hs, res_hs;

  // push_ready depends only on registered occupancy, never on pop_ready_i.
  assign push_ready_o = (count_q != CW'(DEPTH));
  assign pop_valid_o  = (count_q != '0) && (inflight_q < 4'(MAX_INFLIGHT));
  assign push_hs      = push_valid_i && push_ready_o;
  assign pop_hs       = pop_valid_o && pop_ready_i;
  assign res_hs       = result_valid_i && result_ready_i;

  assign instr_o    = (count_q != '0) ? mem_q[rd_ptr_q].instr : 32'h0;
  assign rs1_o      = (count_q != '0) ? mem_q[rd_ptr_q].rs1   : 32'h0;
  assign count_o    = count_q;
  assign inflight_o = inflight_q;
  assign busy_o     = (count_q != '0) || (inflight_q != '0);
  assign err_o      = err_q;

  always_comb begin
    mem_d = mem_q;
    if (push_hs) mem_d[wr_ptr_q] = '{instr: instr_i, rs1: rs1_i};
  end

  always_comb begin
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    count_d    = count_q;
    inflight_d = inflight_q;
    err_d      = err_q;
    if (flush_i) begin
      wr_ptr_d   = '0;
      rd_ptr_d   = '0;
      count_d    = '0;
      inflight_d = '0;
    end else begin
      if (push_hs) wr_ptr_d = wr_ptr_q + AW'(1);
      if (pop_hs)  rd_ptr_d = rd_ptr_q + AW'(1);
      count_d = count_q + CW'(push_hs) - CW'(pop_hs);
      // A result with nothing outstanding is a protocol error; the count saturates at 0.
      if (pop_hs && !res_hs)
        inflight_d = inflight_q + 4'd1;
      else if (res_hs && !pop_hs && inflight_q != '0)
        inflight_d = inflight_q - 4'd1;
      if (res_hs && inflight_q == '0) err_d = 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      inflight_q <= '0;
      err_q      <= 1'b0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      inflight_q <= inflight_d;
      err_q      <= err_d;
    end
  end

  always_ff @(posedge clk_i) begin
    mem_q <= mem_d;
  end
endmodule
